// File: rtl/ysyx_22041461_dcache_nway_if.sv
// LSU-side and memory-side handshake bundles for the N-way data cache.

// LSU <-> cache request/response channel
interface ysyx_22041461_dcache_nway_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [63:0]       req_wdata;
  logic [7:0]        req_mask;
  logic              resp_valid;
  logic [63:0]       resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_mask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_mask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// cache <-> bus bridge memory channel
interface ysyx_22041461_dcache_nway_mem_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [63:0]       req_wdata;
  logic [7:0]        req_mask;
  logic              resp_valid;
  logic [63:0]       resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_mask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_mask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ysyx_22041461_dcache_nway.sv
// N-way set-associative, blocking, write-through / no-write-allocate data cache.
// One 64-bit word per line; tag/valid/data held in flops; round-robin victim per set.
module ysyx_22041461_dcache_nway #(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned SETS     = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_LAST = 64'h0000_0000_8fff_ffff
) (
  input  logic clk,
  input  logic flush,
  input  logic inv,
  ysyx_22041461_dcache_nway_if.slave      lsu,
  ysyx_22041461_dcache_nway_mem_if.master mem
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - 3 - IDX_W;
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(MEM_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_LAST);

  typedef enum logic [2:0] {
    IDLE, FILL_REQ, FILL_WAIT, UC_REQ, UC_WAIT, WR_REQ, WR_WAIT
  } state_e;

  state_e state, state_nx;

  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [63:0]      data_q  [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic              mem_req_wen_q;
  logic [63:0]       mem_req_wdata_q;
  logic [7:0]        mem_req_mask_q;
  logic              resp_valid_q;
  logic [63:0]       resp_rdata_q;

  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic             in_cacheable;
  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic             hit;
  logic [63:0]      hit_line;
  logic [63:0]      merged;
  logic             req_ready;
  logic             accept;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [WAY_W-1:0] victim;
  logic             use_rr;

  assign in_idx       = lsu.req_addr[IDX_W+2:3];
  assign in_tag       = lsu.req_addr[ADDR_W-1:IDX_W+3];
  assign in_cacheable = (lsu.req_addr >= BASE) && (lsu.req_addr <= LAST);
  assign req_ready    = (state == IDLE) && !inv;
  assign accept       = lsu.req_valid && req_ready;

  // Fill index/tag come from the held request address (low 3 bits cleared only).
  assign fill_idx = mem_req_addr_q[IDX_W+2:3];
  assign fill_tag = mem_req_addr_q[ADDR_W-1:IDX_W+3];
  assign use_rr   = &valid_q[fill_idx];

  // Tag compare against the incoming request address
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[in_idx][w] && (tag_q[in_idx][w] == in_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit      = (|hit_vec) && in_cacheable;
  assign hit_line = data_q[in_idx][hit_way];

  // Byte-masked merge of store data into the hit line
  always_comb begin
    merged = hit_line;
    for (int b = 0; b < 8; b++) begin
      if (lsu.req_mask[b]) merged[8*b +: 8] = lsu.req_wdata[8*b +: 8];
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim = rr_q[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) victim = WAY_W'(w);
    end
  end

  // State register
  always_ff @(posedge clk or negedge flush) begin
    if (!flush) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (lsu.req_wen)        state_nx = WR_REQ;
          else if (!in_cacheable) state_nx = UC_REQ;
          else if (!hit)          state_nx = FILL_REQ;
        end
      end
      FILL_REQ:  if (mem.req_ready)  state_nx = FILL_WAIT;
      FILL_WAIT: if (mem.resp_valid) state_nx = IDLE;
      UC_REQ:    if (mem.req_ready)  state_nx = UC_WAIT;
      UC_WAIT:   if (mem.resp_valid) state_nx = IDLE;
      WR_REQ:    if (mem.req_ready)  state_nx = WR_WAIT;
      WR_WAIT:   if (mem.resp_valid) state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // Memory request register: loaded on accept, held until handshake
  always_ff @(posedge clk or negedge flush) begin
    if (!flush) begin
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wen_q   <= 1'b0;
      mem_req_wdata_q <= '0;
      mem_req_mask_q  <= '0;
    end else if ((state == IDLE) && accept && (state_nx != IDLE)) begin
      mem_req_valid_q <= 1'b1;
      mem_req_wen_q   <= lsu.req_wen;
      mem_req_addr_q  <= (state_nx == FILL_REQ) ? {lsu.req_addr[ADDR_W-1:3], 3'b000}
                                                : lsu.req_addr;
      mem_req_wdata_q <= lsu.req_wen ? lsu.req_wdata : 64'd0;
      mem_req_mask_q  <= lsu.req_wen ? lsu.req_mask  : 8'hff;
    end else if (mem_req_valid_q && mem.req_ready) begin
      mem_req_valid_q <= 1'b0;
    end
  end

  // Valid bits, round-robin pointers and the LSU response
  always_ff @(posedge clk or negedge flush) begin
    if (!flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if ((state == IDLE) && inv) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (accept && hit && !lsu.req_wen) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= hit_line;
      end
      if (mem.resp_valid) begin
        unique case (state)
          FILL_WAIT: begin
            valid_q[fill_idx][victim] <= 1'b1;
            if (use_rr) rr_q[fill_idx] <= WAY_W'(rr_q[fill_idx] + 1'b1);
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem.resp_rdata;
          end
          UC_WAIT: begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem.resp_rdata;
          end
          WR_WAIT: begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Tag/data arrays; writes gated off while reset is asserted
  always_ff @(posedge clk) begin
    if (flush && accept && hit && lsu.req_wen) begin
      data_q[in_idx][hit_way] <= merged;
    end
    if (flush && (state == FILL_WAIT) && mem.resp_valid) begin
      data_q[fill_idx][victim] <= mem.resp_rdata;
      tag_q[fill_idx][victim]  <= fill_tag;
    end
  end

  assign lsu.req_ready  = req_ready;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;

  assign mem.req_valid = mem_req_valid_q;
  assign mem.req_addr  = mem_req_addr_q;
  assign mem.req_wen   = mem_req_wen_q;
  assign mem.req_wdata = mem_req_wdata_q;
  assign mem.req_mask  = mem_req_mask_q;

endmodule

// File: tb/tb_ysyx_22041461_dcache_nway.sv
// Directed bench for ysyx_22041461_dcache_nway (WAYS=2, SETS=64).
module tb_ysyx_22041461_dcache_nway;

  logic clk;
  logic flush;
  logic inv;

  ysyx_22041461_dcache_nway_if     #(.ADDR_W(64)) lsu_if ();
  ysyx_22041461_dcache_nway_mem_if #(.ADDR_W(64)) mem_if ();

  ysyx_22041461_dcache_nway #(
    .WAYS(2), .SETS(64), .ADDR_W(64)
  ) dut (
    .clk   (clk),
    .flush (flush),
    .inv   (inv),
    .lsu   (lsu_if),
    .mem   (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // observations from the last access
  logic        mem_seen;
  logic [63:0] m_addr;
  logic        m_wen;
  logic [7:0]  m_mask;
  logic [63:0] m_wdata;
  logic [63:0] got_data;
  int          lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One LSU transaction; the bench plays memory (stall cycles before ready, mdata as response)
  task automatic access(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                        input logic [7:0] mask, input int stall, input logic [63:0] mdata);
    int   cyc;
    logic done;
    mem_seen = 1'b0;
    done     = 1'b0;
    cyc      = 0;
    @(negedge clk);
    chk("req_ready_idle", lsu_if.req_ready, 1'b1);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_addr  = addr;
    lsu_if.req_wen   = wen;
    lsu_if.req_wdata = wdata;
    lsu_if.req_mask  = mask;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    while (!done && cyc < 40) begin
      if (lsu_if.resp_valid) begin
        done     = 1'b1;
        got_data = lsu_if.resp_rdata;
      end else if (mem_if.req_valid && !mem_seen) begin
        mem_seen = 1'b1;
        m_addr   = mem_if.req_addr;
        m_wen    = mem_if.req_wen;
        m_mask   = mem_if.req_mask;
        m_wdata  = mem_if.req_wdata;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          cyc++;
          chk("stall_valid", mem_if.req_valid, 1'b1);
          chk("stall_addr",  mem_if.req_addr,  m_addr);
          chk("stall_mask",  mem_if.req_mask,  m_mask);
          chk("stall_ready", lsu_if.req_ready, 1'b0);
        end
        mem_if.req_ready = 1'b1;
        @(negedge clk);
        cyc++;
        mem_if.req_ready  = 1'b0;
        chk("mreq_drop", mem_if.req_valid, 1'b0);
        mem_if.resp_valid = 1'b1;
        mem_if.resp_rdata = mdata;
        @(negedge clk);
        cyc++;
        mem_if.resp_valid = 1'b0;
        mem_if.resp_rdata = '0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    lat = cyc;
    chk("resp_seen", done, 1'b1);
    if (done) begin
      @(negedge clk);
      chk("resp_pulse", lsu_if.resp_valid, 1'b0);
      chk("resp_hold",  lsu_if.resp_rdata, got_data);
    end
  endtask

  task automatic ld_miss(input logic [63:0] addr, input int stall, input logic [63:0] mdata);
    access(addr, 1'b0, 64'h0, 8'h00, stall, mdata);
    chk("miss_mem",  mem_seen, 1'b1);
    chk("miss_addr", m_addr, {addr[63:3], 3'b000});
    chk("miss_wen",  m_wen, 1'b0);
    chk("miss_mask", m_mask, 8'hff);
    chk("miss_data", got_data, mdata);
    chk("miss_lat",  64'(lat), 64'(2 + stall));
  endtask

  task automatic ld_hit(input logic [63:0] addr, input logic [63:0] exp);
    access(addr, 1'b0, 64'h0, 8'h00, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("hit_nomem", mem_seen, 1'b0);
    chk("hit_data",  got_data, exp);
    chk("hit_lat",   64'(lat), 64'd0);
  endtask

  task automatic ld_uc(input logic [63:0] addr, input logic [63:0] mdata);
    access(addr, 1'b0, 64'h0, 8'h00, 0, mdata);
    chk("uc_mem",  mem_seen, 1'b1);
    chk("uc_addr", m_addr, addr);
    chk("uc_wen",  m_wen, 1'b0);
    chk("uc_mask", m_mask, 8'hff);
    chk("uc_data", got_data, mdata);
  endtask

  task automatic st(input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] mask);
    access(addr, 1'b1, wdata, mask, 0, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("st_mem",   mem_seen, 1'b1);
    chk("st_addr",  m_addr, addr);
    chk("st_wen",   m_wen, 1'b1);
    chk("st_mask",  m_mask, mask);
    chk("st_wdata", m_wdata, wdata);
    chk("st_rdata", got_data, 64'h0);
    chk("st_lat",   64'(lat), 64'd2);
  endtask

  initial begin
    flush = 1'b0;
    inv   = 1'b0;
    lsu_if.req_valid  = 1'b0;
    lsu_if.req_addr   = '0;
    lsu_if.req_wen    = 1'b0;
    lsu_if.req_wdata  = '0;
    lsu_if.req_mask   = '0;
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", lsu_if.resp_valid, 1'b0);
    chk("rst_resp_rdata", lsu_if.resp_rdata, 64'h0);
    chk("rst_mreq_valid", mem_if.req_valid, 1'b0);
    chk("rst_mreq_addr",  mem_if.req_addr, 64'h0);
    chk("rst_mreq_mask",  mem_if.req_mask, 8'h00);
    flush = 1'b1;
    @(negedge clk);

    // fill then hit
    ld_miss(64'h8000_0010, 0, 64'h1122_3344_5566_7788);
    ld_hit (64'h8000_0010, 64'h1122_3344_5566_7788);

    // store hit merges low four bytes; store miss does not allocate
    st    (64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    ld_hit(64'h8000_0010, 64'h1122_3344_CCCC_DDDD);
    st    (64'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF);
    ld_miss(64'h8000_0020, 0, 64'h0000_0000_0000_5555);

    // three tags in set 0: round-robin replacement
    ld_miss(64'h8000_0000, 0, 64'hD000_0000_0000_0000);
    ld_miss(64'h8000_0200, 0, 64'hD000_0000_0000_0200);
    ld_miss(64'h8000_0400, 0, 64'hD000_0000_0000_0400);
    ld_hit (64'h8000_0200, 64'hD000_0000_0000_0200);
    ld_hit (64'h8000_0400, 64'hD000_0000_0000_0400);
    ld_miss(64'h8000_0000, 0, 64'hD100_0000_0000_0000);
    ld_hit (64'h8000_0400, 64'hD000_0000_0000_0400);
    ld_hit (64'h8000_0000, 64'hD100_0000_0000_0000);
    ld_miss(64'h8000_0200, 0, 64'hD100_0000_0000_0200);

    // uncached window and its boundaries
    ld_uc(64'hA000_03F8, 64'hCAFE_0000_0000_0001);
    ld_uc(64'hA000_03F8, 64'hCAFE_0000_0000_0002);
    ld_uc(64'hA000_03FC, 64'hCAFE_0000_0000_0003);
    ld_uc(64'h7FFF_FFF8, 64'hCAFE_0000_0000_0004);
    ld_uc(64'h9000_0000, 64'hCAFE_0000_0000_0005);
    ld_miss(64'h8FFF_FFF8, 0, 64'hBEEF_0000_0000_0006);
    ld_hit (64'h8FFF_FFF8, 64'hBEEF_0000_0000_0006);
    st    (64'hA000_0004, 64'h1111_2222_3333_4444, 8'h81);

    // memory back-pressure, then invalidate-all
    ld_miss(64'h8000_0100, 5, 64'h7777_6666_5555_4444);
    ld_hit (64'h8000_0100, 64'h7777_6666_5555_4444);
    @(negedge clk);
    inv = 1'b1;
    #1;
    chk("inv_ready", lsu_if.req_ready, 1'b0);
    @(negedge clk);
    inv = 1'b0;
    #1;
    chk("inv_ready_back", lsu_if.req_ready, 1'b1);
    ld_miss(64'h8000_0100, 0, 64'h7777_6666_5555_0000);

    // async reset during FILL_WAIT abandons the fill
    @(negedge clk);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_addr  = 64'h8000_0300;
    lsu_if.req_wen   = 1'b0;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    chk("rf_mreq_valid", mem_if.req_valid, 1'b1);
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    flush = 1'b0;
    #1;
    chk("rf_mreq_cleared", mem_if.req_valid, 1'b0);
    chk("rf_resp_cleared", lsu_if.resp_valid, 1'b0);
    chk("rf_rdata_cleared", lsu_if.resp_rdata, 64'h0);
    mem_if.resp_valid = 1'b1;
    mem_if.resp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    mem_if.resp_valid = 1'b0;
    mem_if.resp_rdata = '0;
    flush = 1'b1;
    @(negedge clk);
    chk("rf_no_resp", lsu_if.resp_valid, 1'b0);
    ld_miss(64'h8000_0300, 0, 64'h3333_0000_0000_0300);
    ld_miss(64'h8000_0010, 0, 64'h1010_1010_1010_1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
